// File: rtl/coproc_io_master_if.sv
// coproc_io_master_if: command/response handshake bundle for coproc_io_master.
interface coproc_io_master_if #(
   parameter int N = 64
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [2:0]    cmd_op;
   logic [14:0]   cmd_addr;
   logic [N-1:0]  cmd_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [N-1:0]  rsp_data;
   logic          rsp_err;
   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err
   );
   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/coproc_io_master.sv
// coproc_io_master: command-driven register/CSR access master that halts a coprocessor core.
// Optional halt watchdog enabled by defining COPROC_HALT_WDT_EN.
module coproc_io_master #(
   parameter int N          = 64,
   parameter int WDT_CYCLES = 65535
) (
   input  logic              clk,
   input  logic              reset_n,
   coproc_io_master_if.slave bus,
   output logic              halted,
   output logic [14:0]       coprocessorIOAddr,
   output logic [4:0]        coprocessorIOControl,
   output logic [N-1:0]      coprocessorIODataOut,
   input  logic [N-1:0]      coprocessorIODataIn
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ISSUE  = 2'd1;
   localparam logic [1:0] SAMPLE = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;
   localparam logic [2:0] OP_NOP    = 3'd0;
   localparam logic [2:0] OP_HALT   = 3'd1;
   localparam logic [2:0] OP_RESUME = 3'd2;
   localparam logic [2:0] OP_RD_REG = 3'd3;
   localparam logic [2:0] OP_WR_REG = 3'd4;
   localparam logic [2:0] OP_RD_CSR = 3'd5;
   localparam logic [2:0] OP_WR_CSR = 3'd6;
   logic [1:0]   state;
   logic [2:0]   op;
   logic         access;
   logic [N-1:0] rsp_data_q;
   logic         rsp_err_q;
   logic         accept, cmd_access, cmd_wr, is_rd, is_csr, wdt_expire;
   assign accept     = state == IDLE && bus.cmd_valid;
   assign cmd_access = bus.cmd_op inside {OP_RD_REG, OP_WR_REG, OP_RD_CSR, OP_WR_CSR};
   assign cmd_wr     = bus.cmd_op == OP_WR_REG || bus.cmd_op == OP_WR_CSR;
   assign is_rd      = op == OP_RD_REG || op == OP_RD_CSR;
   assign is_csr     = op == OP_RD_CSR || op == OP_WR_CSR;
   assign bus.cmd_ready = state == IDLE;
   assign bus.rsp_valid = state == RESP;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   // bit [1] mirrors halted in every state so any non-zero control freezes the core PC
   always_comb
      coprocessorIOControl = (state == ISSUE && access) ? {1'b0, is_csr, is_rd, halted, !is_rd} :
                             (state == SAMPLE)          ? {1'b0, is_csr, 1'b1, halted, 1'b0} :
                                                          {3'b000, halted, 1'b0};
`ifdef COPROC_HALT_WDT_EN
   localparam int WW = $clog2(WDT_CYCLES + 1);
   logic [WW-1:0] wdt_cnt;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n)
         wdt_cnt <= '0;
      else
         wdt_cnt <= (!halted || state != IDLE || bus.cmd_valid) ? '0 : wdt_cnt + 1'b1;
   assign wdt_expire = halted && state == IDLE && !bus.cmd_valid && wdt_cnt == WW'(WDT_CYCLES - 1);
`else
   assign wdt_expire = WDT_CYCLES < 0;
`endif
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state                <= IDLE;
         op                   <= OP_NOP;
         access               <= 1'b0;
         halted               <= 1'b0;
         rsp_data_q           <= '0;
         rsp_err_q            <= 1'b0;
         coprocessorIOAddr    <= '0;
         coprocessorIODataOut <= '0;
      end else
         case (state)
            IDLE: begin
               if (wdt_expire)
                  halted <= 1'b0;
               if (accept) begin
                  state  <= ISSUE;
                  op     <= bus.cmd_op;
                  access <= cmd_access && halted;
                  if (cmd_access && halted)
                     coprocessorIOAddr <= bus.cmd_addr;
                  if (cmd_wr && halted)
                     coprocessorIODataOut <= bus.cmd_wdata;
               end
            end
            ISSUE: begin
               state      <= (access && is_rd) ? SAMPLE : RESP;
               rsp_data_q <= '0;
               rsp_err_q  <= !(access || op <= OP_RESUME);
               halted     <= op == OP_HALT ? 1'b1 : op == OP_RESUME ? 1'b0 : halted;
            end
            SAMPLE: begin
               state      <= RESP;
               rsp_data_q <= coprocessorIODataIn;
            end
            default:
               if (bus.rsp_ready)
                  state <= IDLE;
         endcase
endmodule

// File: tb/tb_coproc_io_master.sv
// tb_coproc_io_master: randomized self-checking bench for coproc_io_master against a
// transaction-level model of halt state, response contents, latency and core-side strobes.
module tb_coproc_io_master;
   localparam int N = 64;
   logic          clk = 1'b0;
   logic          reset_n;
   logic          halted;
   logic [14:0]   io_addr;
   logic [4:0]    io_ctl;
   logic [N-1:0]  io_dout;
   logic [N-1:0]  io_din;
   int            n_cmp = 0;
   int            n_err = 0;
   logic          m_halted;
   logic [14:0]   m_addr;
   logic [N-1:0]  m_dout;

   coproc_io_master_if #(.N(N)) bus ();

   coproc_io_master #(.N(N), .WDT_CYCLES(16)) dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .bus                  (bus),
      .halted               (halted),
      .coprocessorIOAddr    (io_addr),
      .coprocessorIOControl (io_ctl),
      .coprocessorIODataOut (io_dout),
      .coprocessorIODataIn  (io_din)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic model_reset();
      m_halted = 1'b0;
      m_addr   = '0;
      m_dout   = '0;
   endtask

   // One complete command: acceptance, access cycles, optional backpressure, response transfer.
   task automatic send(input logic [2:0] op, input logic [14:0] addr, input logic [N-1:0] wd,
                       input logic [N-1:0] din, input int hold);
      logic acc, rd, csr, ex_err, ex_halt;
      logic [N-1:0] ex_data;
      logic [4:0] ex_ctl;
      int lat;
      acc     = m_halted && op inside {[3'd3:3'd6]};
      rd      = acc && (op == 3'd3 || op == 3'd5);
      csr     = op == 3'd5 || op == 3'd6;
      lat     = rd ? 3 : 2;
      ex_ctl  = acc ? {1'b0, csr, rd, 1'b1, !rd} : 5'b0;
      ex_err  = !(op <= 3'd2 || acc);
      ex_data = rd ? din : '0;
      ex_halt = op == 3'd1 ? 1'b1 : op == 3'd2 ? 1'b0 : m_halted;
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wd;
      bus.rsp_ready = 1'b0;
      io_din        = din;
      n_cmp++;
      if (bus.cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL cmd_ready_idle op=%0d: got %b expected 1", op, bus.cmd_ready);
      end
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 3'($urandom);
      bus.cmd_addr  = 15'($urandom);
      bus.cmd_wdata = {$urandom, $urandom};
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         if (c < lat) begin
            n_cmp++;
            if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin
               n_err++;
               $display("FAIL early_rsp op=%0d cyc=%0d: got valid=%b ready=%b expected 0/0", op, c, bus.rsp_valid, bus.cmd_ready);
            end
            n_cmp++;
            if (acc ? (io_ctl !== ex_ctl) : ((io_ctl & 5'b11101) !== 5'b0)) begin
               n_err++;
               $display("FAIL ctl op=%0d cyc=%0d: got %b expected %b", op, c, io_ctl, ex_ctl);
            end
            if (acc) begin
               n_cmp++;
               if (io_addr !== addr || (!rd && io_dout !== wd)) begin
                  n_err++;
                  $display("FAIL access_bus op=%0d: got addr=%h dout=%h expected addr=%h dout=%h", op, io_addr, io_dout, addr, wd);
               end
            end
         end else begin
            n_cmp++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== ex_data || bus.rsp_err !== ex_err) begin
               n_err++;
               $display("FAIL rsp op=%0d lat=%0d: got valid=%b data=%h err=%b expected 1 %h %b", op, lat, bus.rsp_valid, bus.rsp_data, bus.rsp_err, ex_data, ex_err);
            end
         end
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         io_din = {$urandom, $urandom};
         n_cmp++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== ex_data || bus.rsp_err !== ex_err || bus.cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rsp_hold op=%0d h=%0d: got valid=%b data=%h err=%b ready=%b expected 1 %h %b 0", op, h, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.cmd_ready, ex_data, ex_err);
         end
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      if (acc) m_addr = addr;
      if (acc && !rd) m_dout = wd;
      m_halted = ex_halt;
      @(negedge clk);
      n_cmp++;
      if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || halted !== m_halted || io_ctl !== {3'b000, m_halted, 1'b0}) begin
         n_err++;
         $display("FAIL after_rsp op=%0d: got valid=%b ready=%b halted=%b ctl=%b expected 0 1 %b %b", op, bus.rsp_valid, bus.cmd_ready, halted, io_ctl, m_halted, {3'b000, m_halted, 1'b0});
      end
      n_cmp++;
      if (io_addr !== m_addr || io_dout !== m_dout) begin
         n_err++;
         $display("FAIL bus_hold op=%0d: got addr=%h dout=%h expected %h %h", op, io_addr, io_dout, m_addr, m_dout);
      end
   endtask

   task automatic check_reset_values(input string tag);
      n_cmp++;
      if (halted !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0 || bus.rsp_err !== 1'b0 ||
          io_addr !== '0 || io_ctl !== '0 || io_dout !== '0) begin
         n_err++;
         $display("FAIL %s: got halted=%b valid=%b data=%h err=%b addr=%h ctl=%b dout=%h expected all 0", tag, halted, bus.rsp_valid, bus.rsp_data, bus.rsp_err, io_addr, io_ctl, io_dout);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #1;
      check_reset_values("reset_values");
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      n_cmp++;
      if (bus.cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready: got %b expected 1", bus.cmd_ready);
      end
   endtask

   task automatic test_directed();
      send(3'd1, 15'd0, '0, '0, 0);
      send(3'd4, 15'd5, 64'hDEAD_BEEF, '0, 0);
      send(3'd5, 15'h300, '0, 64'h1800, 0);
      send(3'd1, 15'd0, '0, '0, 0);
      send(3'd2, 15'd0, '0, '0, 0);
      send(3'd3, 15'd1, '0, 64'h1234, 0);
      send(3'd7, 15'd1, 64'h55, 64'h1234, 0);
      send(3'd6, 15'h7FF, 64'h99, '0, 1);
      send(3'd0, 15'd0, '0, '0, 0);
   endtask

   task automatic test_backpressure();
      send(3'd1, 15'd0, '0, '0, 0);
      send(3'd3, 15'd7, '0, {$urandom, $urandom}, 10);
      send(3'd6, 15'h341, {$urandom, $urandom}, '0, 10);
   endtask

   task automatic test_random();
      for (int i = 0; i < 120; i++)
         send(3'($urandom), 15'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 3)));
   endtask

   task automatic test_back_to_back();
      send(3'd1, 15'd0, '0, '0, 0);
      for (int i = 0; i < 8; i++)
         send(i[0] ? 3'd6 : 3'd3, 15'(i), {$urandom, $urandom}, {$urandom, $urandom}, 0);
   endtask

   task automatic test_reset_mid();
      send(3'd1, 15'd0, '0, '0, 0);
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 3'd3;
      bus.cmd_addr  = 15'd9;
      io_din        = 64'hCAFE;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (io_ctl !== 5'b00110) begin
         n_err++;
         $display("FAIL sample_ctl: got %b expected 00110", io_ctl);
      end
      #1;
      reset_n = 1'b0;
      #1;
      check_reset_values("reset_mid_values");
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      send(3'd1, 15'd0, '0, '0, 0);
   endtask

   task automatic test_watchdog();
      logic exp;
      send(3'd1, 15'd0, '0, '0, 0);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
`ifdef COPROC_HALT_WDT_EN
         exp = k < 16;
`else
         exp = 1'b1;
`endif
         n_cmp++;
         if (halted !== exp) begin
            n_err++;
            $display("FAIL watchdog k=%0d: got halted=%b expected %b", k, halted, exp);
         end
      end
      m_halted = halted;
      send(3'd0, 15'd0, '0, '0, 0);
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 3'd0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b0;
      io_din        = '0;
      test_reset();
      test_directed();
      test_backpressure();
      test_random();
      test_back_to_back();
      test_reset_mid();
      test_watchdog();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/coproc_io_master.md
COPROC_IO_MASTER -- requirements
Module: coproc_io_master

Interface
REQ-001 Parameter N, default 64, is the data width of the register/CSR access path.
REQ-002 Parameter WDT_CYCLES, default 65535, is the halt-watchdog limit (used only under REQ-027).
REQ-003 clk  in  1  Single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  Asynchronous, active-low reset.
REQ-005 cmd_valid / cmd_ready  in / out  1 / 1  Command handshake; a command transfers when both are high on a clk edge.
REQ-006 cmd_op  in  3  Command opcode: 000 NOP, 001 HALT, 010 RESUME, 011 RD_REG, 100 WR_REG, 101 RD_CSR, 110 WR_CSR, 111 illegal.
REQ-007 cmd_addr / cmd_wdata  in  15 / N  Target address and write data.
REQ-008 rsp_valid / rsp_ready  out / in  1 / 1  Response handshake; a response transfers when both are high.
REQ-009 rsp_data / rsp_err  out  N / 1  Read data (0 for non-reads); error flag.
REQ-010 halted  out  1  The core is held stopped by this block.
REQ-011 coprocessorIOAddr  out  15  Register index in [4:0]; CSR address in [11:0].
REQ-012 coprocessorIOControl  out  5  [0] write enable, [1] halt hold, [2] read strobe, [3] CSR select, [4] reserved (always 0).
REQ-013 coprocessorIODataOut / coprocessorIODataIn  out / in  N / N  Write data to the core / read data from the core.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, SAMPLE, RESP; cmd_ready SHALL be high only in IDLE.
REQ-015 On an accepted command, the FSM SHALL go IDLE->ISSUE, latching op, addr, and wdata.
REQ-016 Non-ISSUE states SHALL drive coprocessorIOControl = {3'b000, halted, 1'b0}; bit [1] SHALL equal halted in every state, so any non-zero control freezes the core PC.
REQ-017 HALT SHALL set halted in ISSUE and go to RESP (rsp_err=0); HALT while already halted is legal and leaves state unchanged.
REQ-018 RESUME SHALL clear halted in ISSUE and go to RESP (rsp_err=0).
REQ-019 WR_REG/WR_CSR in ISSUE SHALL drive Addr=cmd_addr, DataOut=cmd_wdata, and Control[0]=1 for exactly one cycle; Control[3]=1 for WR_CSR only. The FSM SHALL then go to RESP.
REQ-020 RD_REG/RD_CSR in ISSUE SHALL drive Addr and Control[2]=1, plus Control[3] for RD_CSR, then go to SAMPLE. In SAMPLE, Addr/Control SHALL be held and coprocessorIODataIn captured into rsp_data. The FSM SHALL then go to RESP. Read latency from acceptance to rsp_valid SHALL be 3 cycles; write latency SHALL be 2 cycles.
REQ-021 An access op (RD_*/WR_*) issued while halted=0, or op 111, SHALL drive no core access and go ISSUE->RESP with rsp_err=1 and rsp_data=0.
REQ-022 NOP SHALL produce a response with rsp_err=0 and rsp_data=0.
REQ-023 In RESP, rsp_valid=1, and rsp_data/rsp_err SHALL stay stable until rsp_ready; on transfer the FSM SHALL go to IDLE the same edge and the next command may be accepted the following cycle.
REQ-024 coprocessorIODataOut and coprocessorIOAddr SHALL hold their last values outside ISSUE/SAMPLE; only Control gates effects.

Reset
REQ-025 When reset_n is low, the block SHALL immediately reach state IDLE with halted=0, cmd_ready=1 (after release), rsp_valid=0, rsp_data=0, rsp_err=0, Addr=0, Control=0, and DataOut=0. This holds including reset mid-transaction; any pending response is discarded.
REQ-026 The first command SHALL be accepted no earlier than the first clk edge after reset_n deasserts.

Configuration
REQ-027 With COPROC_HALT_WDT_EN defined, a counter SHALL count cycles while halted=1 and the FSM is in IDLE with cmd_valid=0. It SHALL reset on any accepted command. On reaching WDT_CYCLES it SHALL clear halted with no response generated. Without the macro, halted SHALL clear only via RESUME or reset, and no counter SHALL exist.

Verification
REQ-028 HALT, then WR_REG addr=5 wdata=0xDEAD_BEEF -> Control=5'b00011 for one cycle, Addr[4:0]=5, DataOut=0xDEADBEEF; response err=0 two cycles after acceptance.
REQ-029 Halted, RD_CSR addr=0x300 with DataIn=0x1800 -> Control=5'b01110 for two cycles; rsp_data=0x1800, err=0, rsp_valid three cycles after acceptance.
REQ-030 Not halted, RD_REG addr=1 -> Control stays 0; rsp_err=1, rsp_data=0; op 111 gives the same result.
REQ-031 Hold rsp_ready=0 for 10 cycles on a read -> rsp_valid and rsp_data stay stable and cmd_ready=0 throughout; on rsp_ready=1, return to IDLE.
REQ-032 Assert reset_n=0 during SAMPLE -> all outputs reach reset values asynchronously; after release, HALT is accepted normally.
REQ-033 With COPROC_HALT_WDT_EN and WDT_CYCLES=16, HALT then idle -> halted drops after 16 idle cycles; the same test without the macro keeps halted=1 indefinitely.
